// File: rtl/sdram_write_sched_pkg.sv
// rtl/sdram_write_sched_pkg.sv - shared types and field widths for the SDRAM write scheduler
package sdram_pkg;

  localparam int ROW_W  = 13;
  localparam int COL_W  = 10;
  localparam int BANK_W = 2;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [BANK_W-1:0] bank;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/sdram_write_sched_if.sv
// rtl/sdram_write_sched_if.sv - host request and write-stage handshake bundle
interface sdram_write_sched_if;
  import sdram_pkg::*;

  logic              ivalid;
  logic              oready;
  logic [ROW_W-1:0]  irow;
  logic [COL_W-1:0]  icolumn;
  logic [BANK_W-1:0] ibank;
  logic [DATA_W-1:0] idata;

  logic              oreq;
  logic              oenb;
  logic [ROW_W-1:0]  orow;
  logic [COL_W-1:0]  ocolumn;
  logic [BANK_W-1:0] obank;
  logic [DATA_W-1:0] odata;
  logic              ifin;

  modport master (
    output ivalid, irow, icolumn, ibank, idata, ifin,
    input  oready, oreq, oenb, orow, ocolumn, obank, odata
  );

  modport slave (
    input  ivalid, irow, icolumn, ibank, idata, ifin,
    output oready, oreq, oenb, orow, ocolumn, obank, odata
  );

endinterface

// File: rtl/sdram_wr_fifo.sv
// rtl/sdram_wr_fifo.sv - power-of-two request FIFO with occupancy count
module sdram_wr_fifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         iclk,
  input  logic                         ireset_n,
  input  logic                         push,
  input  logic                         pop,
  input  wr_req_t                      wdata,
  output wr_req_t                      rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wr_req_t         mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge iclk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_write_sched.sv
// rtl/sdram_write_sched.sv - buffers host writes and issues them one burst at a time to sdram_write
module sdram_write_sched
  import sdram_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                         iclk,
  input  logic                         ireset_n,
  input  logic                         iinit_done,
  sdram_write_sched_if.slave           bus,
  output logic                         obusy,
  output logic [$clog2(DEPTH+1)-1:0]   ocount,
  output logic                         oerr
);

  localparam int TW = $clog2(TIMEOUT+1);

  sched_state_t    state;
  logic [TW-1:0]   timer;
  wr_req_t         in_req;
  wr_req_t         head;
  wr_req_t         cur;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            req_q;
  logic            enb_q;

  assign in_req     = '{row: bus.irow, col: bus.icolumn, bank: bus.ibank, data: bus.idata};
  assign push       = bus.ivalid && !full;
  assign pop        = (state == S_IDLE) && iinit_done && !empty;
  assign bus.oready = !full;

  assign bus.oreq    = req_q;
  assign bus.oenb    = enb_q;
  assign bus.orow    = cur.row;
  assign bus.ocolumn = cur.col;
  assign bus.obank   = cur.bank;
  assign bus.odata   = cur.data;

  sdram_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .iclk     (iclk),
    .ireset_n (ireset_n),
    .push     (push),
    .pop      (pop),
    .wdata    (in_req),
    .rdata    (head),
    .full     (full),
    .empty    (empty),
    .count    (ocount)
  );

  // The head is captured on the same edge it is popped, so fields are valid from S_LOAD on.
  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      state <= S_IDLE;
      timer <= '0;
      cur   <= '0;
      req_q <= 1'b0;
      enb_q <= 1'b0;
      obusy <= 1'b0;
      oerr  <= 1'b0;
    end else begin
      req_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            cur   <= head;
            enb_q <= 1'b1;
            obusy <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          req_q <= 1'b1;
          timer <= '0;
          state <= S_REQ;
        end
        S_REQ: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.ifin) begin
            enb_q <= 1'b0;
            state <= S_DONE;
          end else if (timer == TW'(TIMEOUT-1)) begin
            oerr  <= 1'b1;
            enb_q <= 1'b0;
            state <= S_DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DONE: begin
          obusy <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          enb_q <= 1'b0;
          obusy <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
